// File: rtl/blk_rd_engine.sv
// blk_rd_engine: reads one granted block from the packet SRAM and
// streams its words to the output port through a 2-entry return FIFO.
module blk_rd_engine #(
    parameter int PORTNUM        = 16,
    parameter int BLK_ADDR_WIDTH = 10,
    parameter int WORDS_PER_BLK  = 16,
    parameter int TIMES_WIDTH    = $clog2(WORDS_PER_BLK),
    parameter int LEN_WIDTH      = 10,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [$clog2(PORTNUM)-1:0]          i_port,
    input  logic                                i_port_vld,
    input  logic [BLK_ADDR_WIDTH-1:0]           i_blk_addr,
    input  logic                                i_blk_addr_vld,
    input  logic                                i_last_blk_vld,
    input  logic [TIMES_WIDTH-1:0]              i_last_r_times,
    output logic                                o_rd_en,
    output logic [BLK_ADDR_WIDTH+TIMES_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0]               i_rd_data,
    output logic [DATA_WIDTH-1:0]               o_data,
    output logic                                o_data_vld,
    input  logic                                i_out_rdy,
    output logic                                o_sop,
    output logic                                o_eop,
    output logic [$clog2(PORTNUM)-1:0]          o_port,
    output logic [LEN_WIDTH-1:0]                o_len,
    output logic                                o_len_vld,
    output logic                                o_r_done,
    output logic                                o_err
);

    localparam int PW = $clog2(PORTNUM);
    localparam int CW = TIMES_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(WORDS_PER_BLK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [BLK_ADDR_WIDTH-1:0] blk_q, blk_d;
    logic [CW-1:0]             target_q, target_d;
    logic [CW-1:0]             issue_q, issue_d;
    logic [CW-1:0]             dlv_q, dlv_d;
    logic                      last_q, last_d;
    logic                      arrive_q, arrive_d;
    logic [DATA_WIDTH-1:0]     head_q, head_d;
    logic [DATA_WIDTH-1:0]     skid_q, skid_d;
    logic                      head_vld_q, head_vld_d;
    logic                      skid_vld_q, skid_vld_d;
    logic                      sop_pend_q, sop_pend_d;
    logic                      hdr_pend_q, hdr_pend_d;
    logic [PW-1:0]             port_q, port_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic                      len_vld_q, len_vld_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic       accept;
    logic       rd_en;
    logic       last_beat;
    logic [1:0] credit;

    assign accept    = head_vld_q & i_out_rdy;
    assign last_beat = accept & (dlv_q == target_q - CW'(1));

    // Counting the beat leaving this cycle keeps 1 word/cycle at full rate
    // while still guaranteeing every outstanding read has a FIFO slot.
    assign credit = 2'(arrive_q) + 2'(head_vld_q) + 2'(skid_vld_q)
                  - 2'(accept);

    assign rd_en = (state_q == S_READ) && (issue_q < target_q)
                && (credit < 2'd2);

    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        target_d   = target_q;
        issue_d    = issue_q;
        dlv_d      = dlv_q;
        last_d     = last_q;
        arrive_d   = rd_en;
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        sop_pend_d = sop_pend_q;
        hdr_pend_d = hdr_pend_q;
        port_d     = port_q;
        len_d      = len_q;
        len_vld_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        if (accept) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                skid_vld_d = arrive_q;
                if (arrive_q) begin
                    skid_d = i_rd_data;
                end
            end else begin
                head_vld_d = arrive_q;
                if (arrive_q) begin
                    head_d = i_rd_data;
                end
            end
        end else if (arrive_q) begin
            if (head_vld_q) begin
                skid_d     = i_rd_data;
                skid_vld_d = 1'b1;
            end else begin
                head_d     = i_rd_data;
                head_vld_d = 1'b1;
            end
        end

        if (accept && sop_pend_q) begin
            sop_pend_d = 1'b0;
        end

        if (arrive_q && hdr_pend_q) begin
            len_d      = i_rd_data[LEN_WIDTH-1:0];
            len_vld_d  = 1'b1;
            hdr_pend_d = 1'b0;
        end

        if (i_port_vld) begin
            port_d     = i_port;
            sop_pend_d = 1'b1;
            hdr_pend_d = 1'b1;
        end

        if (rd_en) begin
            issue_d = issue_q + CW'(1);
        end
        if (accept) begin
            dlv_d = dlv_q + CW'(1);
        end

        if (i_blk_addr_vld && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_blk_addr_vld) begin
                    blk_d    = i_blk_addr;
                    target_d = i_last_blk_vld
                             ? {1'b0, i_last_r_times} + CW'(1)
                             : FULL_CNT;
                    last_d   = i_last_blk_vld;
                    issue_d  = '0;
                    dlv_d    = '0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if (rd_en && (issue_q + CW'(1) == target_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_beat) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            blk_q      <= '0;
            target_q   <= '0;
            issue_q    <= '0;
            dlv_q      <= '0;
            last_q     <= 1'b0;
            arrive_q   <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            sop_pend_q <= 1'b0;
            hdr_pend_q <= 1'b0;
            port_q     <= '0;
            len_q      <= '0;
            len_vld_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            target_q   <= target_d;
            issue_q    <= issue_d;
            dlv_q      <= dlv_d;
            last_q     <= last_d;
            arrive_q   <= arrive_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            sop_pend_q <= sop_pend_d;
            hdr_pend_q <= hdr_pend_d;
            port_q     <= port_d;
            len_q      <= len_d;
            len_vld_q  <= len_vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_rd_en    = rd_en;
    assign o_rd_addr  = {blk_q, issue_q[TIMES_WIDTH-1:0]};
    assign o_data     = head_q;
    assign o_data_vld = head_vld_q;
    assign o_sop      = head_vld_q & sop_pend_q;
    assign o_eop      = head_vld_q & last_q
                      & (dlv_q == target_q - CW'(1));
    assign o_port     = port_q;
    assign o_len      = len_q;
    assign o_len_vld  = len_vld_q;
    assign o_r_done   = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_blk_rd_engine.sv
// tb_blk_rd_engine: random block reads against an SRAM model and a
// per-block expectation built from the block/packet rules.
module tb_blk_rd_engine;

    localparam int BAW = 10;
    localparam int TW  = 4;
    localparam int DW  = 32;
    localparam int LW  = 10;
    localparam int PW  = 4;
    localparam int WPB = 16;
    localparam int AW  = BAW + TW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] port;
    logic          port_vld;
    logic [BAW-1:0] blk;
    logic          blk_vld;
    logic          last_vld;
    logic [TW-1:0] lrt;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] data;
    logic          data_vld;
    logic          out_rdy;
    logic          sop;
    logic          eop;
    logic [PW-1:0] oport;
    logic [LW-1:0] len;
    logic          len_vld;
    logic          r_done;
    logic          err;

    always #5 clk = ~clk;

    blk_rd_engine dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_port         (port),
        .i_port_vld     (port_vld),
        .i_blk_addr     (blk),
        .i_blk_addr_vld (blk_vld),
        .i_last_blk_vld (last_vld),
        .i_last_r_times (lrt),
        .o_rd_en        (rd_en),
        .o_rd_addr      (rd_addr),
        .i_rd_data      (rd_data),
        .o_data         (data),
        .o_data_vld     (data_vld),
        .i_out_rdy      (out_rdy),
        .o_sop          (sop),
        .o_eop          (eop),
        .o_port         (oport),
        .o_len          (len),
        .o_len_vld      (len_vld),
        .o_r_done       (r_done),
        .o_err          (err)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
        logic [PW-1:0] p;
        int            cyc;
    } beat_t;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    beat_t         beats[$];
    logic [AW-1:0] reads[$];
    int            read_cyc[$];
    int            done_cyc[$];
    logic [LW-1:0] lens[$];

    int            n_chk;
    int            n_fail;
    int            cyc;
    int            issued;
    int            accepted;
    int            credit_max;
    int            stab_bad;
    bit            mon_en;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [PW-1:0] cur_port;
    bit            err_exp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SRAM: data for a read seen in cycle N is presented during N+1
    initial begin
        logic          pend;
        logic [AW-1:0] pa;
        rd_data = '0;
        forever begin
            @(negedge clk);
            pend = rd_en;
            pa   = rd_addr;
            @(posedge clk);
            #1;
            rd_data = pend ? mem[pa] : '0;
        end
    end

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (issued - accepted > credit_max)
                    credit_max = issued - accepted;
                if (prev_stall && !(data_vld && data === prev_data))
                    stab_bad++;
                prev_stall = data_vld && !out_rdy;
                prev_data  = data;
                if (rd_en) begin
                    reads.push_back(rd_addr);
                    read_cyc.push_back(cyc);
                    issued++;
                end
                if (data_vld && out_rdy) begin
                    beats.push_back('{data, sop, eop, oport, cyc});
                    accepted++;
                end
                if (r_done) done_cyc.push_back(cyc);
                if (len_vld) lens.push_back(len);
            end
        end
    end

    task automatic mon_clear();
        reads.delete();
        read_cyc.delete();
        beats.delete();
        done_cyc.delete();
        lens.delete();
        issued     = 0;
        accepted   = 0;
        credit_max = 0;
        stab_bad   = 0;
        prev_stall = 0;
        mon_en     = 1;
    endtask

    task automatic run_block(input string nm, input logic [BAW-1:0] b,
                             input bit lst, input logic [TW-1:0] lr,
                             input bit newp, input logic [PW-1:0] p,
                             input bit same_cyc, input int rdy_pct,
                             input int busy_at);
        int tgt;
        int n;
        int m;
        logic [AW-1:0] ea;
        tgt = lst ? int'(lr) + 1 : WPB;
        mon_clear();
        if (newp) cur_port = p;
        if (newp && !same_cyc) begin
            port = p;
            port_vld = 1;
            tick();
            port_vld = 0;
        end
        if (newp && same_cyc) begin
            port = p;
            port_vld = 1;
        end
        blk = b;
        blk_vld = 1;
        last_vld = lst;
        lrt = lr;
        out_rdy = ($urandom_range(99) < rdy_pct);
        tick();
        blk_vld = 0;
        port_vld = 0;
        last_vld = 0;
        n = 0;
        while (done_cyc.size() == 0 && n < 300) begin
            out_rdy = ($urandom_range(99) < rdy_pct);
            if (n == busy_at) begin
                blk = ~b;
                blk_vld = 1;
                last_vld = 1;
            end
            tick();
            blk_vld = 0;
            last_vld = 0;
            n++;
        end
        if (busy_at >= 0) err_exp = 1;
        out_rdy = 1;
        tick();
        tick();
        mon_en = 0;

        chk({nm, "_timeout"}, n >= 300, 0);
        chk({nm, "_nreads"}, reads.size(), tgt);
        m = reads.size() < tgt ? reads.size() : tgt;
        for (int i = 0; i < m; i++) begin
            ea = AW'(int'(b) * WPB + i);
            chk({nm, "_rd_addr"}, reads[i], ea);
        end
        chk({nm, "_nbeats"}, beats.size(), tgt);
        m = beats.size() < tgt ? beats.size() : tgt;
        for (int i = 0; i < m; i++) begin
            ea = AW'(int'(b) * WPB + i);
            chk({nm, "_data"}, beats[i].d, mem[ea]);
            chk({nm, "_sop"}, beats[i].s, newp && i == 0);
            chk({nm, "_eop"}, beats[i].e, lst && i == tgt - 1);
            chk({nm, "_port"}, beats[i].p, cur_port);
        end
        chk({nm, "_ndone"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0 && beats.size() > 0)
            chk({nm, "_done_cyc"}, done_cyc[0], beats[$].cyc + 1);
        chk({nm, "_credit_ok"}, credit_max <= 2, 1);
        chk({nm, "_stable"}, stab_bad, 0);
        chk({nm, "_nlen"}, lens.size(), newp ? 1 : 0);
        if (newp && lens.size() > 0) begin
            ea = AW'(int'(b) * WPB);
            chk({nm, "_len"}, lens[0], mem[ea][LW-1:0]);
        end
        if (rdy_pct >= 100 && reads.size() > 0 && beats.size() > 0) begin
            chk({nm, "_rd_span"}, read_cyc[$] - read_cyc[0], tgt - 1);
            chk({nm, "_latency"}, beats[0].cyc - read_cyc[0], 2);
        end
        chk({nm, "_err"}, err, err_exp);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        mon_en = 0;
        err_exp = 0;
        cur_port = '0;
        rst_n = 0;
        port = '0;
        port_vld = 0;
        blk = '0;
        blk_vld = 0;
        last_vld = 0;
        lrt = '0;
        out_rdy = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[14'h050] = 32'h0000_0064;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_ctl", {rd_en, rd_addr, data_vld, sop, eop, oport,
                        len, len_vld, r_done, err}, 0);
        tick();
        rst_n = 1;
        tick();

        run_block("full", 10'h005, 0, 4'd0, 1, 4'd3, 0, 100, -1);
        chk("hdr_len100", lens.size() > 0 ? lens[0] : 10'h3FF, 100);
        run_block("last3", 10'h3FF, 1, 4'd2, 0, 4'd3, 0, 100, -1);
        run_block("last1", 10'h012, 1, 4'd0, 1, 4'd9, 1, 100, -1);
        run_block("bp_full", BAW'($urandom), 0, 4'd0, 1,
                  PW'($urandom), 0, 50, -1);
        run_block("bp_last", BAW'($urandom), 1, TW'($urandom), 0,
                  4'd0, 0, 40, -1);

        // reset in the middle of a block
        mon_clear();
        port = 4'd5;
        port_vld = 1;
        blk = 10'h0A0;
        blk_vld = 1;
        last_vld = 0;
        out_rdy = 1;
        tick();
        port_vld = 0;
        blk_vld = 0;
        for (int k = 0; k < 50 && accepted < 5; k++) tick();
        chk("mid_beats", accepted >= 5, 1);
        rst_n = 0;
        tick();
        @(negedge clk);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_ctl", {rd_en, rd_addr, data_vld, sop, eop, oport,
                            len, len_vld, r_done, err}, 0);
        tick();
        rst_n = 1;
        repeat (4) tick();
        mon_en = 0;
        chk("mid_no_done", done_cyc.size(), 0);
        run_block("after_rst", 10'h0A0, 0, 4'd0, 1, 4'd5, 0, 100, -1);

        run_block("busy", 10'h155, 0, 4'd0, 1, 4'd7, 0, 100, 3);
        run_block("sticky", 10'h2AA, 1, 4'd5, 0, 4'd0, 0, 70, -1);

        for (int r = 0; r < 6; r++) begin
            run_block("rand", BAW'($urandom), 1'($urandom),
                      TW'($urandom), 1'($urandom), PW'($urandom),
                      1'($urandom), $urandom_range(30, 100), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
